// File: rtl/instruction_memory_responder.sv
// Instruction memory responder: one-outstanding fetch port with fixed latency,
// side-band load port; Clk/Reset, Req*/Rsp* handshakes, Load* write port.
module instruction_memory_responder #(
  parameter int LATENCY = 2,
  parameter int DEPTH   = 128
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        ReqValid,
  input  logic [31:0] ReqAddress,
  output logic        ReqReady,
  output logic        RspValid,
  input  logic        RspReady,
  output logic [31:0] Instruction,
  output logic        RspError,
  input  logic        LoadEn,
  input  logic [31:0] LoadAddress,
  input  logic [31:0] LoadData
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] CNT_INIT =
    (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [2:0]  cnt;
  logic [31:0] data_q;
  logic        err_q;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic          req_err;
  logic          ld_ok;
  logic [AW-1:0] req_idx;
  logic [AW-1:0] ld_idx;

  assign req_idx = ReqAddress[AW+1:2];
  assign ld_idx  = LoadAddress[AW+1:2];

  assign req_err = (|ReqAddress[1:0]) ||
    ({2'b00, ReqAddress[31:2]} >= 32'(DEPTH));

  assign ld_ok = LoadEn && !(|LoadAddress[1:0]) &&
    ({2'b00, LoadAddress[31:2]} < 32'(DEPTH));

  assign accept = ReqValid && ReqReady;

  // Storage is deliberately outside the reset domain.
  always_ff @(posedge Clk) begin
    if (ld_ok) begin
      mem[ld_idx] <= LoadData;
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = (LATENCY > 1) ? WAIT : RESP;
        end
      end
      WAIT: begin
        if (cnt == 3'd0) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (RspReady) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The read samples mem before any same-edge load lands,
  // so a colliding load is only visible to later requests.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      cnt    <= 3'd0;
      data_q <= 32'h0;
      err_q  <= 1'b0;
    end else if (accept) begin
      cnt    <= CNT_INIT;
      data_q <= req_err ? 32'h0 : mem[req_idx];
      err_q  <= req_err;
    end else if (state == WAIT && cnt != 3'd0) begin
      cnt <= cnt - 3'd1;
    end
  end

  always_comb begin
    ReqReady    = (state == IDLE);
    RspValid    = (state == RESP);
    Instruction = RspValid ? data_q : 32'h0;
    RspError    = RspValid && err_q;
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Bench for instruction_memory_responder: vector table, corner sequences,
// randomized traffic against a reference model; LATENCY 1/2/8 builds.
module tb_instruction_memory_responder;

  localparam int DEPTH = 128;
  localparam int LAT = 2;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        ReqValid;
  logic [31:0] ReqAddress;
  logic        RspReady;
  logic        LoadEn;
  logic [31:0] LoadAddress;
  logic [31:0] LoadData;

  logic        rdy2, rv2, err2;
  logic [31:0] ins2;
  logic        rdy1, rv1, err1;
  logic [31:0] ins1;
  logic        rdy8, rv8, err8;
  logic [31:0] ins8;

  always #5 Clk = ~Clk;

  instruction_memory_responder #(.LATENCY(2), .DEPTH(DEPTH)) dut2 (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqAddress(ReqAddress), .ReqReady(rdy2),
    .RspValid(rv2), .RspReady(RspReady),
    .Instruction(ins2), .RspError(err2),
    .LoadEn(LoadEn), .LoadAddress(LoadAddress), .LoadData(LoadData)
  );

  instruction_memory_responder #(.LATENCY(1), .DEPTH(DEPTH)) dut1 (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqAddress(ReqAddress), .ReqReady(rdy1),
    .RspValid(rv1), .RspReady(RspReady),
    .Instruction(ins1), .RspError(err1),
    .LoadEn(LoadEn), .LoadAddress(LoadAddress), .LoadData(LoadData)
  );

  instruction_memory_responder #(.LATENCY(8), .DEPTH(DEPTH)) dut8 (
    .Clk(Clk), .Reset(Reset),
    .ReqValid(ReqValid), .ReqAddress(ReqAddress), .ReqReady(rdy8),
    .RspValid(rv8), .RspReady(RspReady),
    .Instruction(ins8), .RspError(err8),
    .LoadEn(LoadEn), .LoadAddress(LoadAddress), .LoadData(LoadData)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  // Issue one request with RspReady=1. lat counts edges from the
  // accepting edge (edge 1) to the edge after which RspValid is seen.
  task automatic fetch(input logic [31:0] a, output logic [31:0] ins,
                       output logic err, output int lat);
    chk("fetch_ready", 32'(rdy2), 32'd1);
    ReqValid   = 1'b1;
    ReqAddress = a;
    RspReady   = 1'b1;
    lat = 0;
    ins = 32'h0;
    err = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      ReqValid = 1'b0;
      LoadEn   = 1'b0;
      if (rv2) begin
        lat = n;
        ins = ins2;
        err = err2;
        break;
      end
    end
    tick();
    chk("idle_after_rsp", {30'b0, rdy2, rv2}, 32'h2);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    ReqValid = 1'b0;
    LoadEn   = 1'b0;
    RspReady = 1'b1;
    for (int n = 0; n < 30; n++) begin
      if (rdy1 && rdy2 && rdy8) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    chk("drain_all_idle", 32'(ok), 32'd1);
  endtask

  function automatic bit bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a[31:2] >= 30'(DEPTH));
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    logic [31:0] w;
    r = $urandom_range(0, 9);
    w = 32'($urandom_range(0, DEPTH - 1));
    if (r == 0) begin
      return {w[29:0], 2'($urandom_range(1, 3))};
    end
    if (r == 1) begin
      w = 32'($urandom_range(DEPTH, DEPTH + 60));
      return {w[29:0], 2'b00};
    end
    return {w[29:0], 2'b00};
  endfunction

  typedef struct {
    logic        ld;
    logic [31:0] la;
    logic [31:0] ldat;
    logic [31:0] ra;
    logic [31:0] ins;
    logic        err;
    string       nm;
  } vec_t;

  vec_t tbl[8];

  logic [31:0] mmem [DEPTH];
  bit          busy;
  int          age;
  logic [31:0] pdata;
  logic        perr;
  logic        exp_rv;

  logic [31:0] ins;
  logic        err;
  int          lat;
  int          l1, l8;
  bit          seen;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{1'b1, 32'h0000_0000, 32'h8C22_0004,
               32'h0000_0000, 32'h8C22_0004, 1'b0, "load_fetch0"};
    tbl[1] = '{1'b0, 32'h0, 32'h0,
               32'h0000_AB12, 32'h0, 1'b1, "misaligned"};
    tbl[2] = '{1'b0, 32'h0, 32'h0,
               32'hFFFF_FFFF, 32'h0, 1'b1, "all_ones"};
    tbl[3] = '{1'b1, 32'h0000_01FC, 32'hDEAD_BEEF,
               32'h0000_01FC, 32'hDEAD_BEEF, 1'b0, "last_word"};
    tbl[4] = '{1'b0, 32'h0, 32'h0,
               32'h0000_0200, 32'h0, 1'b1, "first_oor"};
    tbl[5] = '{1'b1, 32'h0000_01FE, 32'h1111_1111,
               32'h0000_01FC, 32'hDEAD_BEEF, 1'b0, "mis_load_drop"};
    tbl[6] = '{1'b1, 32'h0000_0200, 32'h5555_5555,
               32'h0000_0000, 32'h8C22_0004, 1'b0, "oor_load_drop"};
    tbl[7] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D,
               32'h0000_0010, 32'hCAFE_F00D, 1'b0, "load_fetch10"};

    Reset       = 1'b0;
    ReqValid    = 1'b0;
    ReqAddress  = 32'h0;
    RspReady    = 1'b0;
    LoadEn      = 1'b0;
    LoadAddress = 32'h0;
    LoadData    = 32'h0;

    // reset state
    tick();
    tick();
    chk("rst_rv", 32'(rv2), 32'd0);
    chk("rst_ins", ins2, 32'h0);
    chk("rst_err", 32'(err2), 32'd0);
    Reset = 1'b1;
    tick();
    chk("rst_ready", 32'(rdy2), 32'd1);
    chk("rst_rv_after", 32'(rv2), 32'd0);

    // vector table
    for (int i = 0; i < 8; i++) begin
      if (tbl[i].ld) begin
        LoadEn      = 1'b1;
        LoadAddress = tbl[i].la;
        LoadData    = tbl[i].ldat;
        tick();
        LoadEn = 1'b0;
      end
      fetch(tbl[i].ra, ins, err, lat);
      chk({tbl[i].nm, "_ins"}, ins, tbl[i].ins);
      chk({tbl[i].nm, "_err"}, 32'(err), 32'(tbl[i].err));
      chk({tbl[i].nm, "_lat"}, 32'(lat), 32'(LAT));
    end

    // stall in RESP with a competing request held on the port
    drain();
    ReqValid   = 1'b1;
    ReqAddress = 32'h0000_0010;
    RspReady   = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      ReqAddress = 32'h0000_0000;
      if (rv2) begin
        seen = 1'b1;
        break;
      end
    end
    chk("stall_resp_seen", 32'(seen), 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk("stall_rv", 32'(rv2), 32'd1);
      chk("stall_ins", ins2, 32'hCAFE_F00D);
      chk("stall_err", 32'(err2), 32'd0);
      chk("stall_ready", 32'(rdy2), 32'd0);
      ReqAddress = 32'(k * 4);
      tick();
    end
    ReqAddress = 32'h0000_0000;
    RspReady   = 1'b1;
    tick();
    chk("stall_hs_ready", 32'(rdy2), 32'd1);
    chk("stall_hs_rv", 32'(rv2), 32'd0);
    tick();
    ReqValid = 1'b0;
    chk("stall_second_wait", 32'(rv2), 32'd0);
    tick();
    chk("stall_second_rv", 32'(rv2), 32'd1);
    chk("stall_second_ins", ins2, 32'h8C22_0004);
    tick();

    // same-edge load and request
    drain();
    LoadEn      = 1'b1;
    LoadAddress = 32'h0000_0004;
    LoadData    = 32'hAAAA_AAAA;
    tick();
    LoadData = 32'h1234_5678;
    fetch(32'h0000_0004, ins, err, lat);
    chk("same_edge_old", ins, 32'hAAAA_AAAA);
    fetch(32'h0000_0004, ins, err, lat);
    chk("same_edge_new", ins, 32'h1234_5678);

    // LATENCY 1 and 8 builds
    drain();
    ReqValid   = 1'b1;
    ReqAddress = 32'h0000_0010;
    RspReady   = 1'b1;
    l1 = 0;
    l8 = 0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      ReqValid = 1'b0;
      if (rv1 && l1 == 0) begin
        l1 = n;
        chk("lat1_ins", ins1, 32'hCAFE_F00D);
      end
      if (rv8 && l8 == 0) begin
        l8 = n;
        chk("lat8_ins", ins8, 32'hCAFE_F00D);
      end
    end
    chk("lat1_edges", 32'(l1), 32'd1);
    chk("lat8_edges", 32'(l8), 32'd8);

    // preload all words, then randomized traffic vs model
    drain();
    for (int i = 0; i < DEPTH; i++) begin
      mmem[i]     = $urandom;
      LoadEn      = 1'b1;
      LoadAddress = 32'(i * 4);
      LoadData    = mmem[i];
      tick();
    end
    LoadEn = 1'b0;
    busy  = 1'b0;
    age   = 0;
    pdata = 32'h0;
    perr  = 1'b0;
    for (int c = 0; c < 600; c++) begin
      ReqValid    = 1'($urandom_range(0, 1));
      ReqAddress  = rand_addr();
      RspReady    = ($urandom_range(0, 2) != 0);
      LoadEn      = ($urandom_range(0, 3) == 0);
      LoadAddress = rand_addr();
      LoadData    = $urandom;
      if (!busy && ReqValid) begin
        busy  = 1'b1;
        age   = 1;
        perr  = bad(ReqAddress);
        pdata = perr ? 32'h0 : mmem[ReqAddress[31:2]];
      end else if (busy && age >= LAT && RspReady) begin
        busy = 1'b0;
      end else if (busy) begin
        age++;
      end
      if (LoadEn && !bad(LoadAddress)) begin
        mmem[LoadAddress[31:2]] = LoadData;
      end
      tick();
      exp_rv = busy && age >= LAT;
      chk("rnd_rv", 32'(rv2), 32'(exp_rv));
      chk("rnd_ready", 32'(rdy2), 32'(!busy));
      chk("rnd_ins", ins2, exp_rv ? pdata : 32'h0);
      chk("rnd_err", 32'(err2), 32'(exp_rv && perr));
    end

    // reset pulse in the middle of WAIT
    drain();
    ReqValid   = 1'b1;
    ReqAddress = 32'h0000_0020;
    RspReady   = 1'b1;
    tick();
    ReqValid = 1'b0;
    chk("midwait_busy", 32'(rdy2), 32'd0);
    Reset = 1'b0;
    #1;
    chk("midrst_rv", 32'(rv2), 32'd0);
    chk("midrst_ins", ins2, 32'h0);
    chk("midrst_err", 32'(err2), 32'd0);
    chk("midrst_ready", 32'(rdy2), 32'd1);
    Reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (rv1 || rv2 || rv8) begin
        seen = 1'b1;
      end
    end
    chk("midrst_no_rsp", 32'(seen), 32'd0);
    fetch(32'h0000_0020, ins, err, lat);
    chk("post_rst_ins", ins, mmem[8]);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_lat", 32'(lat), 32'(LAT));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
